// File: rtl/idecode_pipe.sv
// MIPS decode stage: register file, pending-write scoreboard, RAW/WAW stall,
// one output pipeline register towards EX with valid/ready on both sides.
module idecode_pipe #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter bit WTHRU = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_wdata,
   input  logic            rel_v,
   input  logic [AW-1:0]   rel_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [5:0]      out_opcode,
   output logic [5:0]      out_func,
   output logic [XLEN-1:0] out_rs_val,
   output logic [XLEN-1:0] out_rt_val,
   output logic [XLEN-1:0] out_imm,
   output logic [AW-1:0]   out_rd,
   output logic [NREG-1:0] busy_q
);

   logic [XLEN-1:0] rf_q [NREG];

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [5:0]      out_opcode_q, out_opcode_d;
   logic [5:0]      out_func_q, out_func_d;
   logic [XLEN-1:0] out_rs_val_q, out_rs_val_d;
   logic [XLEN-1:0] out_rt_val_q, out_rt_val_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   logic [AW-1:0]   out_rd_q, out_rd_d;
   logic [NREG-1:0] busy_d;

   logic [5:0]      opc;
   logic [AW-1:0]   rs_idx, rt_idx, dec_rd;
   logic            rs_used, rt_used;
   logic [XLEN-1:0] dec_imm;
   logic [XLEN-1:0] rs_val, rt_val;
   logic [NREG-1:0] clr_now, busy_eff;
   logic            hazard, adv, fire;

   // shamt field is not needed by this stage
   logic            unused_shamt;
   assign unused_shamt = ^in_inst[10:6];

   // Field extraction, destination/source-use decode and immediate extension
   always_comb begin
      opc     = in_inst[31:26];
      rs_idx  = AW'(in_inst[25:21]);
      rt_idx  = AW'(in_inst[20:16]);
      dec_rd  = '0;
      if (opc == 6'b000000)
         dec_rd = AW'(in_inst[15:11]);
      else if (opc[5:3] == 3'b001 || opc[5:3] == 3'b100)
         dec_rd = AW'(in_inst[20:16]);
      else if (opc == 6'b000011 || (opc == 6'b000001 && in_inst[20]))
         dec_rd = AW'(5'd31);
      rs_used = !(opc == 6'b000010 || opc == 6'b000011);
      rt_used = (opc == 6'b000000) || (opc[5:1] == 5'b00010) || (opc[5:3] == 3'b101);
      if (opc[5:2] == 4'b0011)
         dec_imm = {{(XLEN-16){1'b0}}, in_inst[15:0]};
      else
         dec_imm = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
   end

   // Operand read with optional same-cycle writeback bypass; unused sources read 0
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs_used && rs_idx != '0) begin
         rs_val = rf_q[rs_idx];
         if (WTHRU && wb_we && wb_rd == rs_idx) rs_val = wb_wdata;
      end
      if (rt_used && rt_idx != '0) begin
         rt_val = rf_q[rt_idx];
         if (WTHRU && wb_we && wb_rd == rt_idx) rt_val = wb_wdata;
      end
   end

   // Hazard check against the scoreboard, honouring same-cycle releases when bypassing
   always_comb begin
      clr_now = '0;
      if (rel_v) clr_now[rel_rd] = 1'b1;
      if (wb_we) clr_now[wb_rd]  = 1'b1;
      busy_eff = WTHRU ? (busy_q & ~clr_now) : busy_q;
      hazard   = (rs_used && busy_eff[rs_idx]) ||
                 (rt_used && busy_eff[rt_idx]) ||
                 (dec_rd != '0 && busy_eff[dec_rd]);
      adv      = !out_valid_q || out_ready;
      in_ready = adv && !hazard && !flush;
      fire     = in_valid && in_ready;
   end

   // Scoreboard next state: clears first, so a same-cycle set wins
   always_comb begin
      busy_d = busy_q;
      if (rel_v) busy_d[rel_rd] = 1'b0;
      if (wb_we) busy_d[wb_rd]  = 1'b0;
      if (flush && out_valid_q) busy_d[out_rd_q] = 1'b0;
      if (fire && dec_rd != '0) busy_d[dec_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Output register next state: load on issue, drop on consume or flush, else hold
   always_comb begin
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_opcode_d = out_opcode_q;
      out_func_d   = out_func_q;
      out_rs_val_d = out_rs_val_q;
      out_rt_val_d = out_rt_val_q;
      out_imm_d    = out_imm_q;
      out_rd_d     = out_rd_q;
      if (fire) begin
         out_valid_d  = 1'b1;
         out_pc_d     = in_pc;
         out_opcode_d = opc;
         out_func_d   = in_inst[5:0];
         out_rs_val_d = rs_val;
         out_rt_val_d = rt_val;
         out_imm_d    = dec_imm;
         out_rd_d     = dec_rd;
      end else if (flush || out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output pipeline register and scoreboard state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_opcode_q <= '0;
         out_func_q   <= '0;
         out_rs_val_q <= '0;
         out_rt_val_q <= '0;
         out_imm_q    <= '0;
         out_rd_q     <= '0;
         busy_q       <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_opcode_q <= out_opcode_d;
         out_func_q   <= out_func_d;
         out_rs_val_q <= out_rs_val_d;
         out_rt_val_q <= out_rt_val_d;
         out_imm_q    <= out_imm_d;
         out_rd_q     <= out_rd_d;
         busy_q       <= busy_d;
      end
   end

   // Register file; index 0 is never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_we && wb_rd != '0) begin
         rf_q[wb_rd] <= wb_wdata;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pc     = out_pc_q;
   assign out_opcode = out_opcode_q;
   assign out_func   = out_func_q;
   assign out_rs_val = out_rs_val_q;
   assign out_rt_val = out_rt_val_q;
   assign out_imm    = out_imm_q;
   assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_idecode_pipe.sv
// Bench for idecode_pipe: decode vector table, hand-written hazard/flush/stall
// sequences and a randomized run, all against a behavioural model.
module tb_idecode_pipe;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, flush, wb_we, rel_v, out_valid, out_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc, wb_wdata, out_pc, out_rs_val, out_rt_val, out_imm;
   logic [AW-1:0]   wb_rd, rel_rd, out_rd;
   logic [5:0]      out_opcode, out_func;
   logic [NREG-1:0] busy_q;

   idecode_pipe #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .WTHRU(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
      .rel_v(rel_v), .rel_rd(rel_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_func(out_func), .out_rs_val(out_rs_val),
      .out_rt_val(out_rt_val), .out_imm(out_imm), .out_rd(out_rd), .busy_q(busy_q)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_busy [NREG];
   logic [31:0] m_rf   [NREG];
   bit          m_ov;
   logic [31:0] m_pc, m_inst, m_rsv, m_rtv, m_imm;
   int          m_rd;

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_busy[i] = 1'b0;
         m_rf[i]   = '0;
      end
      m_ov = 1'b0; m_pc = '0; m_inst = '0; m_rsv = '0; m_rtv = '0; m_imm = '0; m_rd = 0;
   endtask

   function automatic void mdec(input logic [31:0] inst, output int rd, output bit rs_u,
                                output bit rt_u, output logic [31:0] imm);
      int op;
      op = int'(inst[31:26]);
      if (op == 0)                                     rd = int'(inst[15:11]);
      else if ((op >= 8 && op <= 15) || (op >= 32 && op <= 39)) rd = int'(inst[20:16]);
      else if (op == 3 || (op == 1 && inst[20]))       rd = 31;
      else                                             rd = 0;
      rs_u = !(op == 2 || op == 3);
      rt_u = (op == 0) || (op == 4) || (op == 5) || (op >= 40 && op <= 47);
      if (op >= 12 && op <= 15) imm = {16'h0000, inst[15:0]};
      else                      imm = {{16{inst[15]}}, inst[15:0]};
   endfunction

   function automatic bit eff_busy(input int idx);
      return m_busy[idx] && !(rel_v && int'(rel_rd) == idx) && !(wb_we && int'(wb_rd) == idx);
   endfunction

   function automatic logic [31:0] mread(input int idx);
      if (idx == 0) return '0;
      if (wb_we && int'(wb_rd) == idx) return wb_wdata;
      return m_rf[idx];
   endfunction

   function automatic bit model_ready();
      int rd; bit ru, tu; logic [31:0] imm;
      mdec(in_inst, rd, ru, tu, imm);
      if (flush) return 1'b0;
      if (m_ov && !out_ready) return 1'b0;
      if (ru && eff_busy(int'(in_inst[25:21]))) return 1'b0;
      if (tu && eff_busy(int'(in_inst[20:16]))) return 1'b0;
      if (rd != 0 && eff_busy(rd)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      bit fire; int rd; bit ru, tu; logic [31:0] imm, rsv, rtv;
      fire = in_valid && model_ready();
      mdec(in_inst, rd, ru, tu, imm);
      rsv = ru ? mread(int'(in_inst[25:21])) : 32'h0;
      rtv = tu ? mread(int'(in_inst[20:16])) : 32'h0;
      if (rel_v) m_busy[rel_rd] = 1'b0;
      if (wb_we) m_busy[wb_rd]  = 1'b0;
      if (flush && m_ov) m_busy[m_rd] = 1'b0;
      if (fire && rd != 0) m_busy[rd] = 1'b1;
      if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_wdata;
      if (fire) begin
         m_ov = 1'b1; m_pc = in_pc; m_inst = in_inst;
         m_rsv = rsv; m_rtv = rtv; m_imm = imm; m_rd = rd;
      end else if (flush || (out_ready && m_ov)) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] expb;
      for (int i = 0; i < NREG; i++) expb[i] = m_busy[i];
      chk("out_valid", out_valid, m_ov);
      chk("busy_q", busy_q, expb);
      if (m_ov) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_opcode", out_opcode, m_inst[31:26]);
         chk("out_func", out_func, m_inst[5:0]);
         chk("out_rs_val", out_rs_val, m_rsv);
         chk("out_rt_val", out_rt_val, m_rtv);
         chk("out_imm", out_imm, m_imm);
         chk("out_rd", out_rd, m_rd);
      end
   endtask

   // inputs are driven just after a rising edge; tick checks in_ready, clocks, checks outputs
   task automatic tick();
      #2;
      chk("in_ready", in_ready, model_ready());
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle();
      in_valid = 0; in_inst = '0; in_pc = '0; flush = 0; out_ready = 1;
      wb_we = 0; wb_rd = '0; wb_wdata = '0; rel_v = 0; rel_rd = '0;
   endtask

   task automatic wb_write(input int rd, input logic [31:0] data);
      wb_we = 1; wb_rd = AW'(rd); wb_wdata = data;
      tick();
      wb_we = 0;
   endtask

   task automatic release_rd(input int rd);
      in_valid = 0; rel_v = 1; rel_rd = AW'(rd);
      tick();
      rel_v = 0;
   endtask

   function automatic logic [4:0] rreg();
      int p;
      p = $urandom_range(0, 8);
      return (p == 8) ? 5'd31 : 5'(p);
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [5:0] op;
      case ($urandom_range(0, 12))
         0:  op = 6'h00;
         1:  op = 6'h23;
         2:  op = 6'h2B;
         3:  op = 6'h04;
         4:  op = 6'h05;
         5:  op = 6'h03;
         6:  op = 6'h02;
         7:  op = 6'h01;
         8:  op = 6'h0D;
         9:  op = 6'h09;
         10: op = 6'h0F;
         11: op = 6'h0C;
         default: op = 6'h3F;
      endcase
      return {op, rreg(), rreg(), rreg(), 5'($urandom), 6'($urandom)};
   endfunction

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [31:0] rsv;
      logic [31:0] rtv;
      logic [31:0] imm;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   initial begin
      // register i preloaded with 0x100+i
      vecs[0]  = '{32'h00221821, 5'd3,  32'h101, 32'h102, 32'h00001821}; // addu $3,$1,$2
      vecs[1]  = '{32'h34028000, 5'd2,  32'h0,   32'h0,   32'h00008000}; // ori $2,$0,0x8000
      vecs[2]  = '{32'h24028000, 5'd2,  32'h0,   32'h0,   32'hFFFF8000}; // addiu $2,$0,-0x8000
      vecs[3]  = '{32'h8CC50004, 5'd5,  32'h106, 32'h0,   32'h00000004}; // lw $5,4($6)
      vecs[4]  = '{32'hAD07FFFC, 5'd0,  32'h108, 32'h107, 32'hFFFFFFFC}; // sw $7,-4($8)
      vecs[5]  = '{32'h112A0010, 5'd0,  32'h109, 32'h10A, 32'h00000010}; // beq $9,$10
      vecs[6]  = '{32'h0C000010, 5'd31, 32'h0,   32'h0,   32'h00000010}; // jal
      vecs[7]  = '{32'h08000020, 5'd0,  32'h0,   32'h0,   32'h00000020}; // j
      vecs[8]  = '{32'h04910008, 5'd31, 32'h104, 32'h0,   32'h00000008}; // bgezal $4
      vecs[9]  = '{32'h04800008, 5'd0,  32'h104, 32'h0,   32'h00000008}; // bltz $4
      vecs[10] = '{32'h3C0CABCD, 5'd12, 32'h0,   32'h0,   32'h0000ABCD}; // lui $12
      vecs[11] = '{32'h3085FFFF, 5'd5,  32'h104, 32'h0,   32'h0000FFFF}; // andi $5,$4

      idle();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy_q, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_rs", out_rs_val, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_out_rd", out_rd, 0);
      rst_n = 1;

      for (int i = 1; i < NREG; i++) wb_write(i, 32'h100 + i);
      wb_write(0, 32'hFFFF);

      // decode table
      for (int i = 0; i < NV; i++) begin
         in_valid = 1; in_inst = vecs[i].inst; in_pc = 32'h1000 + 4 * i; out_ready = 1;
         tick();
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
         chk($sformatf("vec%0d_rs", i), out_rs_val, vecs[i].rsv);
         chk($sformatf("vec%0d_rt", i), out_rt_val, vecs[i].rtv);
         chk($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
         chk($sformatf("vec%0d_busy", i), busy_q[vecs[i].rd], vecs[i].rd != 0);
         release_rd(int'(vecs[i].rd));
      end

      // RAW stall released by same-cycle writeback
      in_valid = 1; in_inst = 32'h00221821; in_pc = 32'h4000;
      tick();
      in_inst = 32'h00602025; in_pc = 32'h4004;   // or $4,$3,$0
      for (int k = 0; k < 2; k++) begin
         #2; chk("raw_stall", in_ready, 0);
         tick();
      end
      wb_we = 1; wb_rd = 5'd3; wb_wdata = 32'd9;
      #2; chk("raw_bypass_ready", in_ready, 1);
      tick();
      wb_we = 0; in_valid = 0;
      chk("raw_rs_val", out_rs_val, 9);
      chk("raw_rd", out_rd, 4);
      chk("raw_pc", out_pc, 32'h4004);
      release_rd(4);

      // backpressure: no drop, no duplicate
      out_ready = 0; in_valid = 1; in_inst = 32'hAD07FFFC; in_pc = 32'h2000;
      tick();
      in_inst = 32'h112A0010; in_pc = 32'h2004;
      for (int k = 0; k < 4; k++) begin
         #2; chk("bp_stall", in_ready, 0);
         tick();
         chk("bp_hold_pc", out_pc, 32'h2000);
      end
      out_ready = 1;
      #2; chk("bp_resume", in_ready, 1);
      tick();
      chk("bp_next_pc", out_pc, 32'h2004);
      in_valid = 0;
      tick();
      chk("bp_no_dup", out_valid, 0);

      // flush kills a held lw and releases its destination
      out_ready = 0; in_valid = 1; in_inst = 32'h8CC50004; in_pc = 32'h3000;
      tick();
      chk("fl_busy_set", busy_q[5], 1);
      flush = 1; in_inst = 32'h112A0010; in_pc = 32'h3004;
      #2; chk("fl_no_issue", in_ready, 0);
      tick();
      flush = 0; in_valid = 0; out_ready = 1;
      chk("fl_valid", out_valid, 0);
      chk("fl_busy_clr", busy_q[5], 0);
      tick();

      // jal WAW on $31
      in_valid = 1; in_inst = 32'h0C000010; in_pc = 32'h5000;
      tick();
      chk("jal_rd", out_rd, 31);
      chk("jal_rs", out_rs_val, 0);
      chk("jal_rt", out_rt_val, 0);
      in_pc = 32'h5004;
      for (int k = 0; k < 2; k++) begin
         #2; chk("waw_stall", in_ready, 0);
         tick();
      end
      rel_v = 1; rel_rd = 5'd31;
      #2; chk("waw_release", in_ready, 1);
      tick();
      rel_v = 0; in_valid = 0;
      chk("waw_pc", out_pc, 32'h5004);
      chk("waw_busy", busy_q[31], 1);
      release_rd(31);

      // write to $0 alongside a read of $0
      in_valid = 1; in_inst = 32'h00001821; in_pc = 32'h6000;
      wb_we = 1; wb_rd = 5'd0; wb_wdata = 32'hFFFF;
      tick();
      wb_we = 0; in_valid = 0;
      chk("r0_rs", out_rs_val, 0);
      chk("r0_rt", out_rt_val, 0);
      chk("r0_busy", busy_q[0], 0);
      release_rd(3);

      // asynchronous reset mid-operation
      out_ready = 0; in_valid = 1; in_inst = 32'h8CC50004; in_pc = 32'h7000;
      tick();
      in_valid = 0;
      #2; rst_n = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", busy_q, 0);
      model_reset();
      #2; rst_n = 1;
      idle();
      @(posedge clk); #1;

      // randomized run
      for (int c = 0; c < 3000; c++) begin
         in_valid  = $urandom_range(0, 3) != 0;
         in_inst   = rand_inst();
         in_pc     = $urandom();
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 19) == 0;
         wb_we     = $urandom_range(0, 3) == 0;
         wb_rd     = rreg();
         wb_wdata  = $urandom();
         rel_v     = $urandom_range(0, 2) == 0;
         rel_rd    = rreg();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
